pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- valid/ready sequencer for an NSTAGES-deep datapath pipeline.
//
// Tracks one valid bit per stage and produces the per-stage load enables and
// synchronous clears for the datapath registers. Bubbles collapse: an empty
// stage always loads, even while the output is stalled. A small FSM handles
// drain requests, which stop intake, let the pipeline empty and then pulse
// drained for one cycle.
//
// Parameters
//   NSTAGES    number of pipeline stages (2..16)
// Ports
//   clk        clock, all state updates on its rising edge
//   reset      asynchronous, active-high reset
//   in_valid   upstream offers an item to stage 0
//   in_ready   stage 0 accepts this cycle
//   out_valid  last stage holds an item
//   out_ready  downstream consumes the last stage's item
//   flush      discard every in-flight item (highest priority)
//   drain_req  stop intake and empty the pipeline
//   drained    one-cycle pulse when a drain completes
//   en         per-stage load enable
//   clr        per-stage synchronous clear
//   occupancy  number of valid stages
//   stall_cnt  (PIPE_CTRL_PERF_EN only) cycles with out_valid & !out_ready,
//              saturating, cleared by reset and flush
//
// Optional build macro: PIPE_CTRL_PERF_EN adds the stall_cnt port and counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal operation, items accepted while stage 0 can load
// DRAIN | intake closed, pipeline advances until empty or flushed
// DONE  | drained pulses for this cycle, then back to RUN
module pipe_ctrl #(
  parameter int NSTAGES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  input  logic                         drain_req,
  output logic                         drained,
  output logic [NSTAGES-1:0]           en,
  output logic [NSTAGES-1:0]           clr,
  output logic [$clog2(NSTAGES+1)-1:0] occupancy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int OCC_W = $clog2(NSTAGES+1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NSTAGES-1:0] v;
  logic [NSTAGES:0]   rdy;
  logic               take;

  // A stage can load if it is empty or everything downstream of it moves.
  always_comb begin
    rdy          = '0;
    rdy[NSTAGES] = out_ready & ~flush;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  assign en        = reset ? '0 : (rdy[NSTAGES-1:0] & {NSTAGES{~flush}});
  assign clr       = reset ? '1 : {NSTAGES{flush}};
  assign out_valid = v[NSTAGES-1] & ~flush;
  assign take      = in_valid & in_ready;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (en[0]) v[0] <= take;
      for (int i = 1; i < NSTAGES; i++) begin
        if (en[i]) v[i] <= v[i-1];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = flush ? DONE : DRAIN;
      DRAIN:   if ((occupancy == '0) || flush) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs (state is already RUN while reset is high)
  always_comb begin
    in_ready = ~reset & rdy[0] & (state == RUN) & ~flush;
    drained  = (state == DONE);
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (NSTAGES=4). The reference model keeps
// an array of item ids per stage and moves items forward wherever there is
// room ahead of them; mode is tracked as RUN/DRAIN/DONE from the drain rules.
module tb_pipe_ctrl;

  localparam int N  = 4;
  localparam int OW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          drain_req = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          drained;
  logic [N-1:0]  en;
  logic [N-1:0]  clr;
  logic [OW-1:0] occupancy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  pipe_ctrl #(.NSTAGES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .drain_req (drain_req),
    .drained   (drained),
    .en        (en),
    .clr       (clr),
    .occupancy (occupancy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     slot[N];      // item id per stage, -1 = empty
  int     mode;         // 0 RUN, 1 DRAIN, 2 DONE
  int     next_id;
  longint m_stall;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int j = 0; j < N; j++) if (slot[j] >= 0) c++;
    return c;
  endfunction

  // Stage i moves when the output drains or any stage from i onward is empty.
  function automatic bit m_en(input int i);
    if (flush) return 1'b0;
    if (out_ready) return 1'b1;
    for (int j = i; j < N; j++) if (slot[j] < 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) slot[j] = -1;
    mode    = 0;
    m_stall = 0;
  endtask

  // Called at a falling edge with inputs set; checks, clocks, updates the model.
  task automatic cycle();
    logic [N-1:0] e_en;
    bit           e_inr, e_ov;
    int           occ;
    int           nslot[N];
    #1;
    occ = m_occ();
    for (int i = 0; i < N; i++) e_en[i] = m_en(i);
    e_inr = !flush && (mode == 0) && e_en[0];
    e_ov  = (slot[N-1] >= 0) && !flush;
    check_val("in_ready",  in_ready,  e_inr);
    check_val("out_valid", out_valid, e_ov);
    check_val("en",        en,        e_en);
    check_val("clr",       clr,       flush ? {N{1'b1}} : {N{1'b0}});
    check_val("occupancy", occupancy, occ);
    check_val("drained",   drained,   mode == 2);
`ifdef PIPE_CTRL_PERF_EN
    check_val("stall_cnt", stall_cnt, m_stall);
`endif
    @(posedge clk);
    if (flush) begin
      for (int j = 0; j < N; j++) nslot[j] = -1;
      m_stall = 0;
    end else begin
      for (int j = 0; j < N; j++) nslot[j] = slot[j];
      for (int j = N - 1; j >= 1; j--) if (e_en[j]) nslot[j] = slot[j-1];
      if (e_en[0]) begin
        if (in_valid && e_inr) begin
          nslot[0] = next_id;
          next_id++;
        end else begin
          nslot[0] = -1;
        end
      end
      if (e_ov && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    for (int j = 0; j < N; j++) slot[j] = nslot[j];
    case (mode)
      0:       if (drain_req) mode = flush ? 2 : 1;
      1:       if (occ == 0 || flush) mode = 2;
      default: mode = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic set_in(input logic iv, input logic ordy, input logic fl, input logic dr);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    drain_req = dr;
  endtask

  int n_out;
  int occ0_at, drn_at, n_drn;

  initial begin
    next_id = 0;
    model_reset();

    // reset state
    #3;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_occ",       occupancy, 0);
    check_val("rst_in_ready",  in_ready,  0);
    check_val("rst_drained",   drained,   0);
    check_val("rst_en",        en,        {N{1'b0}});
    check_val("rst_clr",       clr,       {N{1'b1}});
    @(negedge clk);
    reset = 1'b0;

    // streaming: first out_valid at cycle 4, occupancy settles at 4
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1, 0, 0);
      #1;
      check_val("stream_out_valid", out_valid, k >= 4);
      check_val("stream_occ",       occupancy, (k < 4) ? k : 4);
      cycle();
    end

    // backpressure on a full pipeline, then release and count exits
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 0, 0);
      #1;
      check_val("bp_in_ready", in_ready,  0);
      check_val("bp_en",       en,        {N{1'b0}});
      check_val("bp_occ",      occupancy, 4);
      cycle();
    end
    n_out = 0;
    for (int k = 0; k < 6; k++) begin
      set_in(0, 1, 0, 0);
      #1;
      if (out_valid && out_ready) n_out++;
      cycle();
    end
    check_val("bp_exit_count", n_out, 4);

    // flush with occupancy 3
    for (int k = 0; k < 3; k++) begin set_in(1, 0, 0, 0); cycle(); end
    set_in(1, 0, 1, 0);
    #1;
    check_val("fl_occ_before", occupancy, 3);
    check_val("fl_clr",        clr,       {N{1'b1}});
    check_val("fl_in_ready",   in_ready,  0);
    check_val("fl_out_valid",  out_valid, 0);
    cycle();
    set_in(0, 0, 0, 0);
    #1;
    check_val("fl_occ_after", occupancy, 0);
    cycle();

    // drain with occupancy 3
    for (int k = 0; k < 3; k++) begin set_in(1, 0, 0, 0); cycle(); end
    set_in(1, 1, 0, 1);
    cycle();
    occ0_at = -1;
    drn_at  = -1;
    n_drn   = 0;
    for (int k = 0; k < 20; k++) begin
      set_in(1, 1, 0, 0);
      #1;
      if (drn_at < 0 && occ0_at < 0 && occupancy == 0) occ0_at = k;
      if (drained) begin
        n_drn++;
        if (drn_at < 0) drn_at = k;
      end
      if (drn_at < 0) check_val("dr_in_ready_low", in_ready, 0);
      if (drn_at >= 0 && k == drn_at + 1) check_val("dr_in_ready_back", in_ready, 1);
      cycle();
    end
    check_val("dr_pulse_count", n_drn, 1);
    check_val("dr_pulse_timing", drn_at - occ0_at, 1);

    // async reset mid-drain with occupancy 2
    set_in(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) cycle();
    for (int k = 0; k < 2; k++) begin set_in(1, 0, 0, 0); cycle(); end
    set_in(0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0);
    cycle();
    #1;
    check_val("ar_occ_before", occupancy, 2);
    #2;
    reset = 1'b1;
    #1;
    check_val("ar_out_valid", out_valid, 0);
    check_val("ar_occ",       occupancy, 0);
    check_val("ar_in_ready",  in_ready,  0);
    check_val("ar_drained",   drained,   0);
    check_val("ar_en",        en,        {N{1'b0}});
    check_val("ar_clr",       clr,       {N{1'b1}});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_drn = 0;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 0, 0);
      #1;
      if (drained) n_drn++;
      cycle();
    end
    check_val("ar_no_pulse", n_drn, 0);

`ifdef PIPE_CTRL_PERF_EN
    for (int k = 0; k < 4; k++) begin set_in(1, 0, 0, 0); cycle(); end
    for (int k = 0; k < 7; k++) begin set_in(0, 0, 0, 0); cycle(); end
    check_val("perf_stall_7", stall_cnt, 7);
    set_in(0, 0, 1, 0);
    cycle();
    check_val("perf_stall_flush", stall_cnt, 0);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_in(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 29) == 0),
             1'($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
